// File: rtl/icache.sv
// icache: direct-mapped instruction cache, one 32-bit word per line.
//
// Sits between the instruction fetcher (IF_*) and the memory controller (MC_*).
// A hit is answered one cycle after the request. A miss issues a single word
// read, fills the line when MC_commit arrives and returns the word on the
// following cycle.
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst        synchronous active-high reset
//   rdy        global ready; low freezes the cache
//   roll       pipeline rollback, abandons the in-flight fetch
//   IF_flag    fetch request valid, held with IF_addr until IF_hit
//   IF_addr    fetch byte address (bits [1:0] ignored)
//   IF_hit     one-cycle pulse, IF_inst is valid
//   IF_inst    instruction word
//   MC_flag    read request to memory controller, held until MC_commit
//   MC_addr    word-aligned read address
//   MC_commit  one-cycle pulse, MC_data is valid
//   MC_data    fetched word
module icache #(
    parameter int IDX_W = 8,
    parameter int TAG_W = 22
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        roll,
    input  logic        IF_flag,
    input  logic [31:0] IF_addr,
    output logic        IF_hit,
    output logic [31:0] IF_inst,
    output logic        MC_flag,
    output logic [31:0] MC_addr,
    input  logic        MC_commit,
    input  logic [31:0] MC_data
);

    localparam int LINES = 1 << IDX_W;

    typedef enum logic {
        IDLE,
        MISS
    } state_t;

    state_t             r_state;
    logic               r_hit;
    logic [31:0]        r_inst;
    logic               r_mcFlag;
    logic [31:0]        r_mcAddr;
    logic [LINES-1:0]   r_valid;
    logic [31:0]        r_data [LINES];
    logic [TAG_W-1:0]   r_tag  [LINES];

    state_t             w_nextState;
    logic               w_nextHit;
    logic [31:0]        w_nextInst;
    logic               w_nextMcFlag;
    logic [31:0]        w_nextMcAddr;
    logic               w_fill;

    logic [IDX_W-1:0]   w_reqIdx;
    logic [TAG_W-1:0]   w_reqTag;
    logic               w_lookupHit;
    logic [IDX_W-1:0]   w_missIdx;
    logic [TAG_W-1:0]   w_missTag;
    logic               w_unused;

    assign w_reqIdx    = IF_addr[IDX_W+1:2];
    assign w_reqTag    = IF_addr[31:IDX_W+2];
    assign w_lookupHit = r_valid[w_reqIdx] && (r_tag[w_reqIdx] == w_reqTag);

    // The outstanding read address doubles as the latched tag/index of the
    // miss, so a fetcher that changes IF_addr mid-miss cannot corrupt the fill.
    assign w_missIdx = r_mcAddr[IDX_W+1:2];
    assign w_missTag = r_mcAddr[31:IDX_W+2];

    assign w_unused = &{1'b0, IF_addr[1:0]};

    // Next-state and registered-output logic. Priority is roll, then stall,
    // then normal operation; reset is applied in the register process.
    always_comb begin
        w_nextState  = r_state;
        w_nextHit    = 1'b0;
        w_nextInst   = r_inst;
        w_nextMcFlag = r_mcFlag;
        w_nextMcAddr = r_mcAddr;
        w_fill       = 1'b0;

        if (roll) begin
            // A commit arriving with the rollback still carries correct data
            // for the latched address, so keep it in the cache.
            w_nextState  = IDLE;
            w_nextMcFlag = 1'b0;
            w_fill       = (r_state == MISS) && MC_commit;
        end else if (!rdy) begin
            w_nextHit = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    // Skip the cycle right after a response, otherwise the
                    // still-held request would be answered twice.
                    if (r_hit) begin
                        w_nextHit = 1'b0;
                    end else if (IF_flag && w_lookupHit) begin
                        w_nextHit  = 1'b1;
                        w_nextInst = r_data[w_reqIdx];
                    end else if (IF_flag) begin
                        w_nextMcFlag = 1'b1;
                        w_nextMcAddr = {IF_addr[31:2], 2'b00};
                        w_nextState  = MISS;
                    end
                end
                MISS: begin
                    if (MC_commit) begin
                        w_fill       = 1'b1;
                        w_nextHit    = 1'b1;
                        w_nextInst   = MC_data;
                        w_nextMcFlag = 1'b0;
                        w_nextState  = IDLE;
                    end
                end
                default: begin
                    w_nextState = IDLE;
                end
            endcase
        end
    end

    // State and output registers plus the valid bits, all cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_hit    <= 1'b0;
            r_inst   <= 32'h0;
            r_mcFlag <= 1'b0;
            r_mcAddr <= 32'h0;
            r_valid  <= '0;
        end else begin
            r_state  <= w_nextState;
            r_hit    <= w_nextHit;
            r_inst   <= w_nextInst;
            r_mcFlag <= w_nextMcFlag;
            r_mcAddr <= w_nextMcAddr;
            if (w_fill) begin
                r_valid[w_missIdx] <= 1'b1;
            end
        end
    end

    // Data and tag storage is not reset; the valid bits alone decide hits.
    always_ff @(posedge clk) begin
        if (!rst && w_fill) begin
            r_data[w_missIdx] <= MC_data;
            r_tag[w_missIdx]  <= w_missTag;
        end
    end

    assign IF_hit  = r_hit;
    assign IF_inst = r_inst;
    assign MC_flag = r_mcFlag;
    assign MC_addr = r_mcAddr;

endmodule
